// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM arbitration controller.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Fill pattern; the caller truncates to its data width, which gives the mod.
  function automatic logic [31:0] init_pat(input logic [31:0] k);
    return k << 1;
  endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin grant decision; the last-grant pointer lives in the parent.
module ram_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_id,
  output logic       grant_valid,
  output logic       grant_id
);

  assign grant_valid = |valid;
  // On a tie, favour whoever did not win last time.
  assign grant_id    = (&valid) ? ~last_id : valid[1];

endmodule

// File: rtl/ram_arb_ctrl.sv
// Owns the single-port RAM: fills it after reset, then serves two requesters round-robin.
module ram_arb_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W,
  parameter int DEPTH   = RAM_DEPTH,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write,
  output logic              ram_select,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [ADDR_W:0] FILL_END = (ADDR_W+1)'(DEPTH);

  state_e          state, state_nxt;
  logic [ADDR_W:0] kc;
  logic            ptr;
  logic            lat_id;
  logic            gnt_vld, gnt_id;
  logic            hs;
  req_t            sel;

  ram_rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_id     (ptr),
    .grant_valid (gnt_vld),
    .grant_id    (gnt_id)
  );

  assign req0_ready = (state == ST_IDLE) && gnt_vld && (gnt_id == REQ0);
  assign req1_ready = (state == ST_IDLE) && gnt_vld && (gnt_id == REQ1);
  assign hs         = (state == ST_IDLE) && gnt_vld;

  always_comb begin
    sel = (gnt_id == REQ1) ? {req1_write, req1_addr, req1_wdata}
                           : {req0_write, req0_addr, req0_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_EN ? ST_INIT : ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (kc == FILL_END) state_nxt = ST_IDLE;
      ST_IDLE:   if (hs) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // RAM pins are loaded one edge ahead, so they are live in the cycle they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_select  <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      init_done   <= 1'b0;
      ptr         <= REQ1;
      lat_id      <= REQ0;
      kc          <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (kc != FILL_END) begin
            ram_select  <= 1'b1;
            ram_write   <= 1'b1;
            ram_address <= kc[ADDR_W-1:0];
            ram_data_in <= DATA_W'(init_pat(32'(kc)));
            kc          <= kc + 1'b1;
          end else begin
            ram_select <= 1'b0;
            ram_write  <= 1'b0;
            init_done  <= 1'b1;
          end
        end
        ST_IDLE: begin
          init_done <= 1'b1;
          if (hs) begin
            ptr         <= gnt_id;
            lat_id      <= gnt_id;
            ram_select  <= 1'b1;
            ram_write   <= sel.write;
            ram_address <= sel.addr;
            ram_data_in <= sel.wdata;
          end
        end
        ST_ACCESS: begin
          rsp_data   <= ram_write ? ram_data_in : ram_data_out;
          rsp_id     <= lat_id;
          rsp_valid  <= 1'b1;
          ram_select <= 1'b0;
          ram_write  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
